// File: rtl/i2c_reg_pkg.sv
// Shared types and constants for the I2C register bank and its port B controller.
package i2c_reg_pkg;

   typedef enum logic [1:0] {
      B_IDLE = 2'd0,
      B_WAIT = 2'd1,
      B_DONE = 2'd2
   } b_state_t;

   localparam logic [7:0] REG_OOR_RDATA = 8'hFF;
   localparam logic [7:0] REG_ID_ADDR   = 8'h00;

   function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned n);
      return ({24'b0, addr} < n);
   endfunction

endpackage

// File: rtl/reg_port_b_ctrl.sv
// Port B handshake controller: stalls behind port A writes, issues one access strobe
// per request and holds the registered response.
module reg_port_b_ctrl
   import i2c_reg_pkg::*;
#(
   parameter int unsigned NUM_REGS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a_wr,
   input  logic       b_req,
   input  logic       b_we,
   input  logic [7:0] b_addr,
   input  logic [7:0] reg_rdata,
   output logic       b_go,
   output logic       b_wr_en,
   output logic       b_ack,
   output logic       b_err,
   output logic [7:0] b_rdata
);

   b_state_t   state;
   b_state_t   state_next;
   logic       in_range;
   logic       err_q;
   logic [7:0] rdata_q;

   assign in_range = addr_in_range(b_addr, NUM_REGS);
   assign b_wr_en  = b_go & b_we & in_range & (b_addr != REG_ID_ADDR);
   assign b_ack    = (state == B_DONE);
   assign b_err    = err_q;
   assign b_rdata  = rdata_q;

   always_comb begin
      state_next = state;
      b_go       = 1'b0;
      case (state)
         B_IDLE: begin
            if (b_req) begin
               if (a_wr) begin
                  state_next = B_WAIT;
               end else begin
                  b_go       = 1'b1;
                  state_next = B_DONE;
               end
            end
         end
         B_WAIT: begin
            if (!a_wr) begin
               b_go       = 1'b1;
               state_next = B_DONE;
            end
         end
         B_DONE:  state_next = B_IDLE;
         default: state_next = B_IDLE;
      endcase
   end

   // Error flag lives only for the ack cycle; read data persists until the next read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= B_IDLE;
         err_q   <= 1'b0;
         rdata_q <= 8'h00;
      end else begin
         state <= state_next;
         if (b_go) begin
            err_q <= !in_range || (b_we && (b_addr == REG_ID_ADDR));
            if (!b_we) begin
               rdata_q <= in_range ? reg_rdata : REG_OOR_RDATA;
            end
         end else if (state == B_DONE) begin
            err_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/i2c_reg_arbiter.sv
// I2C-visible register bank shared between a never-stalling I2C slave port (A)
// and a req/ack fabric port (B), with dirty tracking of port A writes.
module i2c_reg_arbiter
   import i2c_reg_pkg::*;
#(
   parameter int unsigned          NUM_REGS  = 16,
   parameter logic [7:0]           ID_VALUE  = 8'hA5,
   parameter logic [NUM_REGS-1:0]  A_RO_MASK = NUM_REGS'(16'h0003),
   parameter logic [7:0]           RESET_VAL = 8'h00
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          a_addr,
   input  logic [7:0]          a_wdata,
   input  logic                a_wr,
   input  logic                a_rd,
   output logic [7:0]          a_rdata,
   input  logic                b_req,
   input  logic                b_we,
   input  logic [7:0]          b_addr,
   input  logic [7:0]          b_wdata,
   output logic                b_ack,
   output logic                b_err,
   output logic [7:0]          b_rdata,
   output logic [NUM_REGS-1:0] dirty,
   input  logic [NUM_REGS-1:0] dirty_clr,
   output logic                irq,
   output logic [15:0]         a_rd_cnt
);

   localparam int unsigned AW = $clog2(NUM_REGS);
   // Register 0 holds the ID and must never be writable from the I2C side.
   localparam logic [NUM_REGS-1:0] RO_MASK = A_RO_MASK | NUM_REGS'(1);

   logic [7:0]          regs [NUM_REGS];
   logic [AW-1:0]       a_idx;
   logic [AW-1:0]       b_idx;
   logic                a_in_range;
   logic                a_wr_ok;
   logic [NUM_REGS-1:0] a_set;
   logic                b_go;
   logic                b_wr_en;
   logic [7:0]          b_reg_rdata;

   assign a_idx       = a_addr[AW-1:0];
   assign b_idx       = b_addr[AW-1:0];
   assign a_in_range  = addr_in_range(a_addr, NUM_REGS);
   assign a_wr_ok     = a_wr & a_in_range & ~RO_MASK[a_idx];
   assign a_rdata     = a_in_range ? regs[a_idx] : REG_OOR_RDATA;
   assign b_reg_rdata = regs[b_idx];

   always_comb begin
      a_set = '0;
      if (a_wr_ok) begin
         a_set[a_idx] = 1'b1;
      end
   end

   reg_port_b_ctrl #(
      .NUM_REGS (NUM_REGS)
   ) u_port_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_wr      (a_wr),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .reg_rdata (b_reg_rdata),
      .b_go      (b_go),
      .b_wr_en   (b_wr_en),
      .b_ack     (b_ack),
      .b_err     (b_err),
      .b_rdata   (b_rdata)
   );

   // B only ever accesses on an edge without an A write, so the two writes never collide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == 0) ? ID_VALUE : RESET_VAL;
         end
      end else begin
         if (a_wr_ok) begin
            regs[a_idx] <= a_wdata;
         end
         if (b_wr_en) begin
            regs[b_idx] <= b_wdata;
         end
      end
   end

   // A set wins over a simultaneous clear of the same bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dirty    <= '0;
         irq      <= 1'b0;
         a_rd_cnt <= 16'h0000;
      end else begin
         dirty <= (dirty & ~dirty_clr) | a_set;
         irq   <= |dirty;
         if (a_rd) begin
            a_rd_cnt <= a_rd_cnt + 16'h0001;
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed, table-driven bench for i2c_reg_arbiter with hand sequences for
// back-to-back B requests and extended A-write stalls.
module tb_i2c_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  a_addr, a_wdata, a_rdata;
   logic        a_wr, a_rd;
   logic        b_req, b_we, b_ack, b_err;
   logic [7:0]  b_addr, b_wdata, b_rdata;
   logic [15:0] dirty, dirty_clr, a_rd_cnt;
   logic        irq;

   int vec_count = 0;
   int miscompares = 0;

   typedef struct {
      logic        rst_n;
      logic [7:0]  a_addr;
      logic [7:0]  a_wdata;
      logic        a_wr;
      logic        a_rd;
      logic        b_req;
      logic        b_we;
      logic [7:0]  b_addr;
      logic [7:0]  b_wdata;
      logic [15:0] dirty_clr;
      logic [7:0]  exp_a_rdata;
      logic        exp_ack;
      logic        exp_err;
      logic [7:0]  exp_b_rdata;
      logic [15:0] exp_dirty;
      logic        exp_irq;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   i2c_reg_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_wr      (a_wr),
      .a_rd      (a_rd),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_ack     (b_ack),
      .b_err     (b_err),
      .b_rdata   (b_rdata),
      .dirty     (dirty),
      .dirty_clr (dirty_clr),
      .irq       (irq),
      .a_rd_cnt  (a_rd_cnt)
   );

   function automatic vec_t mkVec(
      input logic r, input logic [7:0] aa, input logic [7:0] awd, input logic awr,
      input logic ard, input logic brq, input logic bwe, input logic [7:0] ba,
      input logic [7:0] bwd, input logic [15:0] clr, input logic [7:0] ea,
      input logic eack, input logic eerr, input logic [7:0] ebr, input logic [15:0] ed,
      input logic eirq, input logic [15:0] ecnt);
      vec_t v;
      v.rst_n = r;       v.a_addr = aa;      v.a_wdata = awd;   v.a_wr = awr;
      v.a_rd = ard;      v.b_req = brq;      v.b_we = bwe;      v.b_addr = ba;
      v.b_wdata = bwd;   v.dirty_clr = clr;  v.exp_a_rdata = ea;
      v.exp_ack = eack;  v.exp_err = eerr;   v.exp_b_rdata = ebr;
      v.exp_dirty = ed;  v.exp_irq = eirq;   v.exp_cnt = ecnt;
      return v;
   endfunction

   task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
         miscompares++;
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst_n     = v.rst_n;
      a_addr    = v.a_addr;
      a_wdata   = v.a_wdata;
      a_wr      = v.a_wr;
      a_rd      = v.a_rd;
      b_req     = v.b_req;
      b_we      = v.b_we;
      b_addr    = v.b_addr;
      b_wdata   = v.b_wdata;
      dirty_clr = v.dirty_clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", idx);
      vec_count++;
      checkField({tag, " a_rdata"}, {8'h00, a_rdata}, {8'h00, v.exp_a_rdata});
      checkField({tag, " b_ack"},   {15'h0, b_ack},   {15'h0, v.exp_ack});
      checkField({tag, " b_err"},   {15'h0, b_err},   {15'h0, v.exp_err});
      checkField({tag, " b_rdata"}, {8'h00, b_rdata}, {8'h00, v.exp_b_rdata});
      checkField({tag, " dirty"},   dirty,            v.exp_dirty);
      checkField({tag, " irq"},     {15'h0, irq},     {15'h0, v.exp_irq});
      checkField({tag, " a_rd_cnt"}, a_rd_cnt,        v.exp_cnt);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cycles;

      // rst, a_addr, a_wdata, a_wr, a_rd, b_req, b_we, b_addr, b_wdata, clr | a_rdata, ack, err, b_rdata, dirty, irq, cnt
      vecs.push_back(mkVec(0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'hA5, 0, 0, 8'h00, 16'h0000, 0, 16'd0));
      vecs.push_back(mkVec(0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'hA5, 0, 0, 8'h00, 16'h0000, 0, 16'd0));
      vecs.push_back(mkVec(1, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 16'h0000, 8'hA5, 0, 0, 8'h00, 16'h0000, 0, 16'd1));
      vecs.push_back(mkVec(1, 8'h05, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'd2));
      vecs.push_back(mkVec(1, 8'h20, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 16'h0000, 8'hFF, 0, 0, 8'h00, 16'h0000, 0, 16'd3));
      vecs.push_back(mkVec(1, 8'h04, 8'h3C, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h3C, 0, 0, 8'h00, 16'h0010, 0, 16'd3));
      vecs.push_back(mkVec(1, 8'h04, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h3C, 0, 0, 8'h00, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h01, 8'h77, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h01, 8'h00, 0, 0, 1, 1, 8'h01, 8'h77, 16'h0000, 8'h77, 1, 0, 8'h00, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h01, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h77, 0, 0, 8'h00, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h04, 8'h99, 1, 0, 1, 0, 8'h04, 8'h00, 16'h0000, 8'h99, 0, 0, 8'h00, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h04, 8'h00, 0, 0, 1, 0, 8'h04, 8'h00, 16'h0000, 8'h99, 1, 0, 8'h99, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h04, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h99, 0, 0, 8'h99, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h00, 8'h00, 0, 0, 1, 1, 8'h00, 8'h11, 16'h0000, 8'hA5, 1, 1, 8'h99, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'hA5, 0, 0, 8'h99, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h00, 8'h00, 0, 0, 1, 1, 8'h40, 8'h22, 16'h0000, 8'hA5, 1, 1, 8'h99, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'hA5, 0, 0, 8'h99, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h00, 8'h00, 0, 0, 1, 0, 8'h40, 8'h00, 16'h0000, 8'hA5, 1, 1, 8'hFF, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'hA5, 0, 0, 8'hFF, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h04, 8'h5A, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0010, 8'h5A, 0, 0, 8'hFF, 16'h0010, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h04, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0010, 8'h5A, 0, 0, 8'hFF, 16'h0000, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h04, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h5A, 0, 0, 8'hFF, 16'h0000, 0, 16'd3));
      vecs.push_back(mkVec(1, 8'h0F, 8'h0F, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h0F, 0, 0, 8'hFF, 16'h8000, 0, 16'd3));
      vecs.push_back(mkVec(1, 8'h10, 8'h01, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'hFF, 0, 0, 8'hFF, 16'h8000, 1, 16'd3));
      vecs.push_back(mkVec(1, 8'h02, 8'h44, 1, 0, 1, 0, 8'h02, 8'h00, 16'h0000, 8'h44, 0, 0, 8'hFF, 16'h8004, 1, 16'd3));
      vecs.push_back(mkVec(0, 8'h02, 8'h00, 0, 0, 1, 0, 8'h02, 8'h00, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'd0));
      vecs.push_back(mkVec(1, 8'h04, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'd0));
      vecs.push_back(mkVec(1, 8'h01, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 16'd0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i]);
      end

      // Held b_req: ack, gap, ack.
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'h00;
      step();
      vec_count++;
      checkField("b2b ack1", {15'h0, b_ack}, 16'h0001);
      checkField("b2b rdata", {8'h00, b_rdata}, 16'h00A5);
      step();
      vec_count++;
      checkField("b2b gap", {15'h0, b_ack}, 16'h0000);
      step();
      vec_count++;
      checkField("b2b ack2", {15'h0, b_ack}, 16'h0001);
      b_req = 1'b0;
      step();
      vec_count++;
      checkField("b2b idle", {15'h0, b_ack}, 16'h0000);

      // B write stalled by three consecutive A writes.
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h06; b_wdata = 8'h34;
      a_addr = 8'h05;
      for (int k = 0; k < 3; k++) begin
         a_wr = 1'b1;
         a_wdata = 8'h12 + 8'(k);
         step();
         vec_count++;
         checkField($sformatf("stall%0d ack", k), {15'h0, b_ack}, 16'h0000);
      end
      a_wr = 1'b0;
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!b_ack && cycles < 10);
      vec_count++;
      checkField("stall ack", {15'h0, b_ack}, 16'h0001);
      checkField("stall latency", 16'(cycles), 16'd1);
      checkField("stall err", {15'h0, b_err}, 16'h0000);
      b_req = 1'b0;
      a_addr = 8'h06;
      step();
      vec_count++;
      checkField("stall reg6", {8'h00, a_rdata}, 16'h0034);
      checkField("stall dirty", dirty, 16'h0020);
      a_addr = 8'h05;
      #1;
      vec_count++;
      checkField("stall reg5", {8'h00, a_rdata}, 16'h0014);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/i2c_reg_arbiter.md
Name: i2c_reg_arbiter

Overview:
- Owns the I2C-visible register bank and shares it between two requesters.
- Port A is the i2c_slave register interface. It is strobe-only and cannot stall, so it always has absolute priority.
- Port B is an internal fabric requester (MCU-side logic, status writers). It uses a req/ack handshake and is stalled on conflict.
- The block also tracks which registers the I2C master has written, through a dirty bitmap and an interrupt.

Parameters:
- NUM_REGS, 16, number of implemented 8-bit registers (2..256).
- ID_VALUE, 8'hA5, constant value of register 0.
- A_RO_MASK, 16'h0003, bit k=1 makes register k read-only from port A (bit 0 is forced to 1).
- RESET_VAL, 8'h00, reset value of registers 1..NUM_REGS-1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous active-low reset.
- a_addr  in  8  port A register address.
- a_wdata  in  8  port A write data.
- a_wr  in  1  port A single-cycle write strobe.
- a_rd  in  1  port A read strobe (informational only; feeds the a_rd_cnt counter).
- a_rdata  out  8  port A read data, combinational from a_addr.
- b_req  in  1  port B request; held with fields stable until b_ack.
- b_we  in  1  port B write (1) / read (0).
- b_addr  in  8  port B address.
- b_wdata  in  8  port B write data.
- b_ack  out  1  port B one-cycle completion pulse.
- b_err  out  1  with b_ack: out-of-range address or write to register 0.
- b_rdata  out  8  port B read data, valid while b_ack=1.
- dirty  out  NUM_REGS  sticky per-register "written by port A" flags.
- dirty_clr  in  NUM_REGS  per-bit clear pulses for dirty.
- irq  out  1  registered OR of dirty.
- a_rd_cnt  out  16  count of a_rd strobes, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - reg[0]=ID_VALUE, all other registers = RESET_VAL.
  - dirty=0, irq=0, b_ack=0, b_err=0, b_rdata=0, a_rd_cnt=0.
  - B FSM goes to B_IDLE. A request in flight is dropped with no ack; the requester must reissue it.
- Port A read:
  - a_rdata = reg[a_addr] combinationally, zero latency.
  - a_addr >= NUM_REGS returns 8'hFF.
- Port A write (a_wr=1 at edge N):
  - reg[a_addr]<=a_wdata at edge N when a_addr < NUM_REGS and A_RO_MASK[a_addr]=0; otherwise ignored.
  - An accepted write sets dirty[a_addr] at edge N. A set has priority over a simultaneous dirty_clr of the same bit.
- irq is registered: it reflects dirty one cycle later.
- B FSM states:
  - B_IDLE:
    - b_req & !a_wr: perform the access at this edge, go to B_DONE.
    - b_req & a_wr: go to B_WAIT.
  - B_WAIT: perform the access on the first edge with a_wr=0, go to B_DONE.
  - B_DONE: b_ack=1, b_err valid, b_rdata valid; go to B_IDLE.
- B timing:
  - Uncontended latency: b_req sampled at edge N -> b_ack high during cycle N+1.
  - b_req held high produces the next access no earlier than edge N+2.
- B access rules:
  - Stall on any a_wr, regardless of address. Ordering is A-then-B: a B read returns the post-A-write value, and a B write to the same register overwrites A's value.
  - B writes ignore A_RO_MASK. Writes to register 0 are ignored with b_err=1.
  - B write with address >= NUM_REGS: ignored, b_err=1.
  - B read with address >= NUM_REGS: b_rdata=8'hFF, b_err=1.
  - B writes never set dirty.
  - b_rdata is registered and holds its value after b_ack.
- Port A is never delayed. A continuous a_wr would starve B; i2c_slave cannot produce back-to-back strobes (one per 9 SCL bits), so no timeout is required.
- a_rd_cnt increments on each a_rd, independent of address.

Decomposition:
- Shared package i2c_reg_pkg:
  - b_state_t enum (B_IDLE, B_WAIT, B_DONE).
  - REG_OOR_RDATA = 8'hFF.
  - REG_ID_ADDR = 8'h00.
- Port B FSM plus access logic is naturally a sub-module, reg_port_b_ctrl. Its outputs are a b_go strobe, an address decode and response registers.
- Storage, the A path and dirty/irq stay in the top module.

Test Plan:
- Reset, then A reads addr 0, 5 and 8'h20 -> a_rdata = 8'hA5, 8'h00, 8'hFF; b_ack=0; irq=0.
- A writes 8'h3C to addr 4 -> reg 4 reads back 8'h3C next cycle; dirty[4]=1; irq=1 one cycle later.
- A writes 8'h77 to addr 1 (masked RO) -> reg 1 is unchanged and dirty[1] stays 0. Then B writes 8'h77 to addr 1 -> b_ack, b_err=0, A reads 8'h77.
- B reads addr 4 with b_req asserted in the same cycle as A writes 8'h99 to addr 4 -> FSM enters B_WAIT; b_ack arrives 1 cycle later than uncontended; b_rdata=8'h99.
- B writes addr 0 and addr 8'h40, then reads 8'h40 -> each access gets b_ack with b_err=1; the read returns 8'hFF; reg 0 is still 8'hA5.
- dirty_clr[4] pulsed in the same cycle as an A write to addr 4 -> dirty[4] stays 1. Clear alone -> dirty[4]=0 and irq=0 next cycle. Then rst_n low while in B_WAIT -> no b_ack and all state back to reset values.
